// File: rtl/systolic_feed_if.sv
// Bus bundle between the systolic feed controller and its environment: operand
// stream handshake, job control, FIFO bank strobes and status.
interface systolic_feed_if #(
  parameter int ROWS    = 4,
  parameter int WORDLEN = 8
);
  logic               start;
  logic [4:0]         k_len;
  logic               in_valid;
  logic [WORDLEN-1:0] in_data;
  logic               in_ready;
  logic [WORDLEN-1:0] buf_din;
  logic [ROWS-1:0]    buf_write;
  logic [ROWS-1:0]    buf_read;
  logic               buf_rstn;
  logic [ROWS-1:0]    row_valid;
  logic               busy;
  logic               done;
  logic [1:0]         err;

  modport master (
    output start, k_len, in_valid, in_data,
    input  in_ready, buf_din, buf_write, buf_read, buf_rstn, row_valid, busy, done, err
  );

  modport slave (
    input  start, k_len, in_valid, in_data,
    output in_ready, buf_din, buf_write, buf_read, buf_rstn, row_valid, busy, done, err
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Loads a column-major operand stream into ROWS row FIFOs, then reads them out in a
// skewed staircase to form the diagonal wavefront of a systolic PE array.
module systolic_feed_ctrl #(
  parameter int ROWS      = 4,
  parameter int WORDLEN   = 8,
  parameter int DEPTH     = 10,
  parameter int PAD       = 0,
  parameter int DRAIN_CYC = 8
) (
  input  logic            clk,
  input  logic            rst,
  systolic_feed_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam int RW = $clog2(ROWS);
  localparam int WW = $clog2(ROWS * 31 + 1);
  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC - 1) : 1;
  localparam logic [4:0] CAP   = 5'(DEPTH - 1);
  localparam logic [4:0] K_MAX = 5'(DEPTH - 1 - PAD);
  localparam logic [4:0] PAD_W = 5'(PAD);

  state_t          state, state_nx;
  logic [4:0]      k;
  logic [WW-1:0]   w;
  logic [RW-1:0]   tr;
  logic [5:0]      t;
  logic [DW-1:0]   dcnt;
  logic [4:0]      occ [ROWS];
  logic [1:0]      err_q;
  logic            rst_q;
  logic [ROWS-1:0] row_valid_q;

  logic            ready, xfer, k_bad;
  logic            load_last, feed_last, drain_last;
  logic [ROWS-1:0] wr, rd;
  logic [WW-1:0]   total;

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    total      = WW'(ROWS) * WW'(k);
    ready      = !rst && (state == S_LOAD) && (occ[tr] < CAP);
    xfer       = ready && bus.in_valid;
    wr         = xfer ? (ROWS'(1) << tr) : '0;
    rd         = '0;
    if (!rst && state == S_FEED) begin
      for (int r = 0; r < ROWS; r++)
        rd[r] = (t >= 6'(r)) && (t < 6'(r) + 6'(k));
    end
    load_last  = xfer && (w == total - WW'(1));
    feed_last  = (t == 6'(k) + 6'(ROWS - 2));
    drain_last = (dcnt == DW'(DRAIN_CYC - 2));
    k_bad      = bus.k_len > K_MAX;
  end

  // The drain window is measured from the last read strobe, so that strobe's own
  // cycle counts as the first of the DRAIN_CYC cycles.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = (bus.k_len == 5'd0 || k_bad) ? S_DONE : S_LOAD;
      S_LOAD:  if (load_last) state_nx = S_FEED;
      S_FEED:  if (feed_last) state_nx = (DRAIN_CYC > 1) ? S_DRAIN : S_DONE;
      S_DRAIN: if (drain_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      k           <= '0;
      w           <= '0;
      tr          <= '0;
      t           <= '0;
      dcnt        <= '0;
      err_q       <= '0;
      rst_q       <= 1'b1;
      row_valid_q <= '0;
      // NOTE: the occupancy array mirrors the FIFO contents and must be reset along
      // with them, including the preloaded pad words.
      for (int r = 0; r < ROWS; r++) occ[r] <= PAD_W;
    end else begin
      state       <= state_nx;
      rst_q       <= 1'b0;
      row_valid_q <= rd;
      case (state)
        S_IDLE: if (bus.start) begin
          k     <= bus.k_len;
          w     <= '0;
          tr    <= '0;
          t     <= '0;
          err_q <= {1'b0, k_bad};
        end
        S_LOAD: if (xfer) begin
          w  <= w + WW'(1);
          tr <= (tr == RW'(ROWS - 1)) ? '0 : tr + RW'(1);
        end
        S_FEED: begin
          t    <= t + 6'd1;
          dcnt <= '0;
        end
        S_DRAIN: dcnt <= dcnt + DW'(1);
        default: ;
      endcase
      // A read on an empty row still goes out; flag it and hold the count at zero.
      for (int r = 0; r < ROWS; r++) begin
        if (wr[r]) begin
          occ[r] <= occ[r] + 5'd1;
        end else if (rd[r]) begin
          if (occ[r] != 5'd0) occ[r] <= occ[r] - 5'd1;
          else                err_q[1] <= 1'b1;
        end
      end
    end
  end

  // Outputs read as their reset values during the rst cycle itself.
  assign bus.in_ready  = ready;
  assign bus.buf_din   = bus.in_data;
  assign bus.buf_write = wr;
  assign bus.buf_read  = rd;
  assign bus.buf_rstn  = !(rst || rst_q);
  assign bus.row_valid = rst ? '0 : row_valid_q;
  assign bus.busy      = !rst && (state != S_IDLE);
  assign bus.done      = !rst && (state == S_DONE);
  assign bus.err       = rst ? 2'b00 : err_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized self-checking bench for systolic_feed_ctrl against a job-level model
// of write targets, staircase read patterns, latency and error flags.
module tb_systolic_feed_ctrl;
  localparam int ROWS      = 4;
  localparam int WORDLEN   = 8;
  localparam int DEPTH     = 10;
  localparam int PAD       = 0;
  localparam int DRAIN_CYC = 8;
  localparam int KMAX      = DEPTH - 1 - PAD;

  logic clk = 1'b0;
  logic rst;

  systolic_feed_if #(.ROWS(ROWS), .WORDLEN(WORDLEN)) bus ();

  systolic_feed_ctrl #(
    .ROWS(ROWS), .WORDLEN(WORDLEN), .DEPTH(DEPTH), .PAD(PAD), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Row r reads while feed cycle t lies in [r, r+k).
  function automatic logic [ROWS-1:0] feed_pattern(input int t, input int k);
    logic [ROWS-1:0] p;
    p = '0;
    for (int r = 0; r < ROWS; r++) p[r] = (t >= r) && (t < r + k);
    return p;
  endfunction

  // mode: 0 continuous stream (data 1,2,3..), 1 valid on even cycles, 2 random valid.
  task automatic run_job(input int k, input int mode, input bit abort, input bit restart);
    bit              legal, ended, aborted, v, exp_ready;
    int              n_words, xfer, last, exp_done, t, dcount;
    logic [WORDLEN-1:0] d;
    logic [ROWS-1:0] exp_rd, prev_rd;
    legal   = (k >= 1) && (k <= KMAX);
    n_words = legal ? ROWS * k : 0;
    xfer    = 0;
    last    = -1;
    ended   = 1'b0;
    aborted = 1'b0;
    prev_rd = '0;
    for (int c = 0; c < 600 && !ended; c++) begin
      bus.start = (c == 0) || (restart && c == 3);
      bus.k_len = (c == 0) ? 5'(k) : ((c == 3) ? 5'(k + 3) : 5'($urandom));
      rst       = abort && (last >= 0) && (c == last + 3);
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (mode == 0) ? WORDLEN'(xfer + 1) : WORDLEN'($urandom);
      bus.in_valid = v;
      bus.in_data  = d;
      @(negedge clk);
      exp_ready = !rst && (c >= 1) && (xfer < n_words);
      t         = c - last - 1;
      exp_rd    = (!rst && last >= 0 && t >= 0 && t <= k + ROWS - 2) ? feed_pattern(t, k) : '0;
      exp_done  = !legal ? 1 : ((last >= 0) ? last + k + ROWS - 1 + DRAIN_CYC : -1);
      check("in_ready", bus.in_ready, exp_ready);
      check("buf_write", bus.buf_write, (v && exp_ready) ? (1 << (xfer % ROWS)) : 0);
      if (v && exp_ready) check("buf_din", bus.buf_din, d);
      check("buf_read", bus.buf_read, exp_rd);
      check("row_valid", bus.row_valid, rst ? '0 : prev_rd);
      check("busy", bus.busy, !rst && (c >= 1) && (exp_done < 0 || c <= exp_done));
      check("done", bus.done, !rst && (c == exp_done));
      check("buf_rstn", bus.buf_rstn, !rst);
      if (c == 1) check("err_after_start", bus.err, {1'b0, k > KMAX});
      if (v && exp_ready) begin
        xfer++;
        if (xfer == n_words) last = c;
      end
      prev_rd = exp_rd;
      if (rst) begin
        aborted = 1'b1;
        ended   = 1'b1;
      end else if (c == exp_done) begin
        check("err_at_done", bus.err, {1'b0, k > KMAX});
        ended = 1'b1;
      end
      if (!ended) begin
        @(posedge clk); #1;
      end
    end
    check("job_end", ended, 1'b1);
    if (!ended) return;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    if (aborted) begin
      check("abort_rstn_hold", bus.buf_rstn, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_read", bus.buf_read, 0);
      check("abort_row_valid", bus.row_valid, 0);
      check("abort_write", bus.buf_write, 0);
      check("abort_err", bus.err, 0);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (i == 0) check("abort_rstn_release", bus.buf_rstn, 1'b1);
        if (bus.done) dcount++;
      end
      check("abort_no_done", dcount, 0);
    end else begin
      check("idle_busy", bus.busy, 1'b0);
      check("idle_done", bus.done, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_write", bus.buf_write, 0);
    check("rst_read", bus.buf_read, 0);
    check("rst_row_valid", bus.row_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rstn", bus.buf_rstn, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstn_hold", bus.buf_rstn, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstn_release", bus.buf_rstn, 1);
    check("idle_busy0", bus.busy, 0);
    @(posedge clk); #1;

    run_job(3, 0, 1'b0, 1'b0);   // continuous stream
    run_job(3, 1, 1'b0, 1'b0);   // stalled stream
    run_job(0, 0, 1'b0, 1'b0);   // empty job
    run_job(10, 0, 1'b0, 1'b0);  // overflow request
    run_job(3, 0, 1'b0, 1'b1);   // start during LOAD ignored, err cleared
    run_job(3, 0, 1'b1, 1'b0);   // reset at FEED t=2
    run_job(KMAX, 2, 1'b0, 1'b0);
    run_job(31, 0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(0, 12), $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
